// File: rtl/smix_pkg.sv
// Shared definitions for the SMix scratchpad controller.
//   BLOCK_W    : width of one scrypt block (r=1 -> 1024 bits)
//   SP_ADDR_W  : width of the scratchpad entry index on the SRAM wrapper port
//   WORD_W     : width of one block word; word k is bits [32k+31:32k]
//   smix_state_t : controller sequencing states
//   integerify : returns word 16 of a block, the source of the loop-2 index
package smix_pkg;

  localparam int BLOCK_W   = 1024;
  localparam int SP_ADDR_W = 17;
  localparam int WORD_W    = 32;

  typedef enum logic [3:0] {
    IDLE,
    WR,
    BM1,
    BM1_W,
    RD,
    RD_W,
    BM2,
    BM2_W,
    DONE
  } smix_state_t;

  // Integerify for r=1: the first word of the second 64-byte half of X.
  function automatic logic [WORD_W-1:0] integerify(input logic [BLOCK_W-1:0] blk);
    return blk[16*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/smix_iter_ctr.sv
// Loop index for both SMix loops.
//   clk, n_rst : clock, asynchronous active-low reset
//   clr        : return the index to 0 (takes priority over inc)
//   inc        : advance the index by one
//   idx        : current iteration index, log2(N) bits
//   last       : high while idx == N-1
// The controller clears the index before each loop and never increments
// past N-1, so the counter never wraps inside a loop.
module smix_iter_ctr #(
  parameter int N  = 1024,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [IW-1:0] idx_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_reg <= '0;
    end else if (clr) begin
      idx_reg <= '0;
    end else if (inc) begin
      idx_reg <= idx_reg + 1'b1;
    end
  end

  assign idx  = idx_reg;
  assign last = (idx_reg == IW'(N - 1));

endmodule

// File: rtl/smix_sp_ctrl.sv
// Initiator side of the SMix scratchpad (scrypt, r=1, 1024-bit X).
// Loop 1 stores X into V[i] and replaces X with BlockMix(X), N times.
// Loop 2 reads V[j] with j = Integerify(X) mod N and replaces X with
// BlockMix(X ^ V[j]), N times.
// Ports:
//   clk, n_rst              : clock, asynchronous active-low reset
//   start, x_in             : job request; x_in sampled on the accepted cycle
//   busy, done, x_out       : busy from the cycle after acceptance through done;
//                             done is a 1-cycle pulse with x_out already valid
//   bm_start, bm_in         : launch pulse and held operand to the blockmix core
//   bm_done, bm_out         : completion pulse and result from the blockmix core
//   sp_r_enable, sp_w_enable: scratchpad strobes, never high together
//   sp_addr                 : entry index, 0 whenever no strobe is high
//   sp_w_data, sp_r_data    : write data (current X) / read data (RD_LAT late)
module smix_sp_ctrl
  import smix_pkg::*;
#(
  parameter int N      = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [BLOCK_W-1:0]   x_in,
  output logic                 busy,
  output logic                 done,
  output logic [BLOCK_W-1:0]   x_out,
  output logic                 bm_start,
  output logic [BLOCK_W-1:0]   bm_in,
  input  logic                 bm_done,
  input  logic [BLOCK_W-1:0]   bm_out,
  output logic                 sp_r_enable,
  output logic                 sp_w_enable,
  output logic [SP_ADDR_W-1:0] sp_addr,
  output logic [BLOCK_W-1:0]   sp_w_data,
  input  logic [BLOCK_W-1:0]   sp_r_data
);

  localparam int IW = $clog2(N);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  smix_state_t state_reg, state_next;

  logic [BLOCK_W-1:0] x_reg;
  logic [BLOCK_W-1:0] bm_in_reg;
  logic [BLOCK_W-1:0] x_out_reg;
  logic [LW-1:0]      lat_reg;

  // Control strobes from the FSM decode to the datapath registers.
  logic ctr_clr, ctr_inc;
  logic ld_x_in, ld_x_bm, ld_bm_x, ld_bm_xv, ld_out;
  logic lat_clr, lat_inc;

  logic [IW-1:0]        idx;
  logic                 last;
  logic [WORD_W-1:0]    intg;
  logic [SP_ADDR_W-1:0] j_addr;
  logic                 lat_done;

  smix_iter_ctr #(
    .N  (N),
    .IW (IW)
  ) u_iter_ctr (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (ctr_clr),
    .inc   (ctr_inc),
    .idx   (idx),
    .last  (last)
  );

  // N is a power of two, so "mod N" is a mask of the low log2(N) bits.
  assign intg     = integerify(x_reg);
  assign j_addr   = SP_ADDR_W'(intg & WORD_W'(N - 1));
  assign lat_done = (lat_reg == LW'(RD_LAT - 1));

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next state, output decode and datapath load strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    busy        = 1'b1;
    done        = 1'b0;
    bm_start    = 1'b0;
    sp_r_enable = 1'b0;
    sp_w_enable = 1'b0;
    sp_addr     = '0;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
    ld_x_in     = 1'b0;
    ld_x_bm     = 1'b0;
    ld_bm_x     = 1'b0;
    ld_bm_xv    = 1'b0;
    ld_out      = 1'b0;
    lat_clr     = 1'b0;
    lat_inc     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          ld_x_in    = 1'b1;
          ctr_clr    = 1'b1;
          state_next = WR;
        end
      end

      WR: begin
        sp_w_enable = 1'b1;
        sp_addr     = SP_ADDR_W'(idx);
        ld_bm_x     = 1'b1;         // operand for the BM1 launch next cycle
        state_next  = BM1;
      end

      BM1: begin
        bm_start   = 1'b1;
        state_next = BM1_W;
      end

      // bm_done arriving in BM1 (same cycle as bm_start) is ignored because
      // only the wait states look at it.
      BM1_W: begin
        if (bm_done) begin
          ld_x_bm = 1'b1;
          if (last) begin
            ctr_clr    = 1'b1;
            state_next = RD;
          end else begin
            ctr_inc    = 1'b1;
            state_next = WR;
          end
        end
      end

      RD: begin
        sp_r_enable = 1'b1;
        sp_addr     = j_addr;
        lat_clr     = 1'b1;
        state_next  = RD_W;
      end

      // Read data is valid in the RD_LAT-th cycle after the strobe, which is
      // the last cycle spent here.
      RD_W: begin
        if (lat_done) begin
          ld_bm_xv   = 1'b1;
          state_next = BM2;
        end else begin
          lat_inc = 1'b1;
        end
      end

      BM2: begin
        bm_start   = 1'b1;
        state_next = BM2_W;
      end

      BM2_W: begin
        if (bm_done) begin
          ld_x_bm = 1'b1;
          if (last) begin
            ld_out     = 1'b1;
            state_next = DONE;
          end else begin
            ctr_inc    = 1'b1;
            state_next = RD;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Read latency counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lat_reg <= '0;
    end else if (lat_clr) begin
      lat_reg <= '0;
    end else if (lat_inc) begin
      lat_reg <= lat_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // V[j] only ever feeds the XOR with X, so the read word is folded into
  // bm_in_reg on capture rather than kept in a separate register; bm_in_reg
  // then holds X ^ V[j] unchanged for the whole BM2/BM2_W window.
  // x_out_reg loads bm_out on the edge into DONE so that it is already valid
  // while done is high.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_reg     <= '0;
      bm_in_reg <= '0;
      x_out_reg <= '0;
    end else begin
      if (ld_x_in) begin
        x_reg <= x_in;
      end else if (ld_x_bm) begin
        x_reg <= bm_out;
      end

      if (ld_bm_x) begin
        bm_in_reg <= x_reg;
      end else if (ld_bm_xv) begin
        bm_in_reg <= x_reg ^ sp_r_data;
      end

      if (ld_out) begin
        x_out_reg <= bm_out;
      end
    end
  end

  assign x_out     = x_out_reg;
  assign bm_in     = bm_in_reg;
  assign sp_w_data = x_reg;

endmodule
